pipeline_stage_hs: RTL and testbench
====================================

Name: pipeline_stage_hs

Overview:
- Parametrised, handshaked successor to the fixed-width pipeline stage register.
- Carries one instruction payload (control word, N register-number fields, immediate) between two CPU pipeline stages.
- Adds valid/ready flow control, flush and bubble insertion (control forced to NOP).
- Adds a saturating stall counter and an optional skid entry that registers in_ready.

Parameters:
- CTRL_W, 22, control word width
- RNUM_W, 3, width of one register-number field
- NUM_RF, 3, number of register-number fields (channel count)
- IMM_W, 16, immediate width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept
- ctrl_in  in  CTRL_W  control word
- rnum_in  in  NUM_RF*RNUM_W  packed register numbers, field k at bits [k*RNUM_W +: RNUM_W]
- imm_in  in  IMM_W  immediate
- flush  in  1  discard all held payloads
- out_valid  out  1  output payload valid
- out_ready  in  1  downstream accepts
- ctrl_out  out  CTRL_W  control word; zero when out_valid=0
- rnum_out  out  NUM_RF*RNUM_W  register numbers
- imm_out  out  IMM_W  immediate
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset: out_valid=0, ctrl_out=0, rnum_out=0, imm_out=0, stall_cnt=0, in_ready=1, skid entry empty.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Latency: an accepted payload appears on the outputs on the next clk edge when the main register is free or emitting.
- Base mode (no skid):
  - in_ready = !out_valid | out_ready (combinational).
  - On accept: main register loads the payload and out_valid<=1.
  - On emit without accept: out_valid<=0.
- Bubble: while out_valid=0, ctrl_out reads 0. rnum_out and imm_out hold their last value.
- Payload is never altered while out_valid=1 and out_ready=0 (stall hold).
- flush:
  - Next cycle out_valid=0 and the skid entry is empty.
  - Any same-cycle accept is discarded; upstream sees it as consumed.
  - flush has priority over accept and emit.
  - flush does not change in_ready in the same cycle.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
- rst during a stall or with the skid entry full: all state returns to reset values next edge; held payloads are lost.
- Simultaneous accept and emit in base mode: throughput 1/cycle, no bubble.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - in_ready is a flop, equal to !skid_full.
  - When the main register is stalled and an accept occurs, the payload goes to the skid entry and in_ready<=0.
  - On emit with skid full: skid moves to main, out_valid stays 1, in_ready<=1.
  - Order is preserved. At most 2 payloads are held.
  - No combinational path from out_ready to in_ready.
- Undefined: base mode only; no skid storage.

Decomposition:
- Package pipe_pkg:
  - default width constants CTRL_W_D=22, RNUM_W_D=3, IMM_W_D=16
  - CTRL_NOP constant (all zeros)
  - function to extract register field k
- One sub-module, pipe_payload_reg: enabled register with synchronous clear. Instantiated once for main, and once more for skid under PIPE_SKID_EN.

Test Plan:
- Reset, then idle -> out_valid=0, ctrl_out=0, in_ready=1, stall_cnt=0.
- Stream: in_valid=1 every cycle with imm=0x0001,0x0002,0x0003, out_ready=1 -> same values on imm_out at cycles 1,2,3, out_valid continuous.
- Stall: accept ctrl=0x2AAAA, then out_ready=0 for 5 cycles -> ctrl_out holds 0x2AAAA, stall_cnt=5.
  - Base: in_ready=0 during the stall.
  - Skid: second payload accepted, then in_ready=0.
- Flush with in_valid=1 and imm=0xBEEF -> next cycle out_valid=0, ctrl_out=0, 0xBEEF never emitted.
- Saturation with CNT_W=3: hold stall 10 cycles -> stall_cnt=7.
- Skid drain (PIPE_SKID_EN): main=A and skid=B full, then out_ready=1 -> A then B emitted on consecutive cycles, in_ready returns to 1 one cycle after A is emitted.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, NOP control word and register-field helper for pipeline_stage_hs
package pipe_pkg;

    localparam int CTRL_W_D = 22;
    localparam int RNUM_W_D = 3;
    localparam int IMM_W_D  = 16;

    localparam logic [CTRL_W_D-1:0] CTRL_NOP = '0;

    // Pull register-number field k (w bits wide) out of a packed field bus.
    function automatic logic [7:0] rnum_field(input logic [63:0] bus, input int k, input int w);
        logic [63:0] s;
        s = (bus >> (k * w)) & ((64'd1 << w) - 64'd1);
        return s[7:0];
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - enabled payload register with synchronous clear
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stage_hs.sv
// rtl/pipeline_stage_hs.sv - handshaked instruction pipeline stage; PIPE_SKID_EN adds a skid entry and a registered in_ready
module pipeline_stage_hs
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_D,
    parameter int RNUM_W = RNUM_W_D,
    parameter int NUM_RF = 3,
    parameter int IMM_W  = IMM_W_D,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        ctrl_in,
    input  logic [NUM_RF*RNUM_W-1:0] rnum_in,
    input  logic [IMM_W-1:0]         imm_in,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        ctrl_out,
    output logic [NUM_RF*RNUM_W-1:0] rnum_out,
    output logic [IMM_W-1:0]         imm_out,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int RN_W = NUM_RF * RNUM_W;
    localparam int P_W  = CTRL_W + RN_W + IMM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [P_W-1:0] in_word;
    logic [P_W-1:0] main_d;
    logic [P_W-1:0] main_q;
    logic           main_en;
    logic           valid_q;
    logic           accept;
    logic           emit;

    assign in_word = {ctrl_in, rnum_in, imm_in};
    assign accept  = in_valid & in_ready;
    assign emit    = valid_q & out_ready;

`ifdef PIPE_SKID_EN
    logic           skid_full;
    logic           skid_en;
    logic           main_free;
    logic [P_W-1:0] skid_q;

    // in_ready depends only on the skid flop, never on out_ready.
    assign in_ready  = !skid_full;
    assign main_free = !valid_q | out_ready;

    always_comb begin
        main_en = 1'b0;
        main_d  = in_word;
        skid_en = 1'b0;
        if (!flush) begin
            if (skid_full && emit) begin
                main_en = 1'b1;
                main_d  = skid_q;
            end else if (accept && main_free) begin
                main_en = 1'b1;
            end else if (accept) begin
                skid_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q   <= 1'b0;
            skid_full <= 1'b0;
        end else begin
            if (skid_full && emit) begin
                skid_full <= 1'b0;
            end else if (accept && !main_free) begin
                skid_full <= 1'b1;
            end
            if (accept && main_free) begin
                valid_q <= 1'b1;
            end else if (emit && !skid_full) begin
                valid_q <= 1'b0;
            end
        end
    end

    pipe_payload_reg #(.W(P_W)) u_skid (
        .clk (clk),
        .clr (rst),
        .en  (skid_en),
        .d   (in_word),
        .q   (skid_q)
    );
`else
    assign in_ready = !valid_q | out_ready;

    always_comb begin
        main_d  = in_word;
        main_en = accept & !flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
        end else if (emit) begin
            valid_q <= 1'b0;
        end
    end
`endif

    pipe_payload_reg #(.W(P_W)) u_main (
        .clk (clk),
        .clr (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (valid_q && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_valid = valid_q;
    assign ctrl_out  = valid_q ? main_q[P_W-1 -: CTRL_W] : CTRL_W'(CTRL_NOP);
    assign rnum_out  = main_q[IMM_W +: RN_W];
    assign imm_out   = main_q[IMM_W-1:0];

endmodule

// File: tb/tb_pipeline_stage_hs.sv
// tb/tb_pipeline_stage_hs.sv - directed and random checks of pipeline_stage_hs against a queue model
module tb_pipeline_stage_hs;
    import pipe_pkg::*;

    typedef struct packed {
        logic [21:0] ctrl;
        logic [8:0]  rnum;
        logic [15:0] imm;
    } payload_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] ctrl_in;
    logic [8:0]  rnum_in;
    logic [15:0] imm_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] ctrl_out;
    logic [8:0]  rnum_out;
    logic [15:0] imm_out;
    logic [2:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    payload_t held[$];
    payload_t last_main;
    int       exp_cnt;

    pipeline_stage_hs #(
        .CTRL_W(22), .RNUM_W(3), .NUM_RF(3), .IMM_W(16), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .rnum_in(rnum_in), .imm_in(imm_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
        .rnum_out(rnum_out), .imm_out(imm_out), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic payload_t mk(input logic [21:0] c, input logic [8:0] r, input logic [15:0] i);
        payload_t p;
        p.ctrl = c;
        p.rnum = r;
        p.imm  = i;
        return p;
    endfunction

    function automatic bit model_ready(input bit ordy);
`ifdef PIPE_SKID_EN
        return held.size() < 2;
`else
        return held.size() == 0 || ordy;
`endif
    endfunction

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(held.size() > 0));
        chk("ctrl_out", 64'(ctrl_out), held.size() > 0 ? 64'(held[0].ctrl) : 64'd0);
        chk("rnum_out", 64'(rnum_out), 64'(last_main.rnum));
        chk("imm_out", 64'(imm_out), 64'(last_main.imm));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    endtask

    // Drive one cycle of inputs, check in_ready, clock, advance the model, check outputs.
    task automatic step(input bit iv, input payload_t p, input bit fl, input bit ordy, input bit r);
        bit rdy, acc, emt;
        in_valid  = iv;
        ctrl_in   = p.ctrl;
        rnum_in   = p.rnum;
        imm_in    = p.imm;
        flush     = fl;
        out_ready = ordy;
        rst       = r;
        #1;
        rdy = model_ready(ordy);
        chk("in_ready", 64'(in_ready), 64'(rdy));
        acc = iv && rdy;
        emt = held.size() > 0 && ordy;
        @(posedge clk);
        #1;
        if (r) begin
            held.delete();
            last_main = '0;
            exp_cnt = 0;
        end else begin
            if (held.size() > 0 && !ordy && exp_cnt < 7) exp_cnt++;
            if (fl) begin
                held.delete();
            end else begin
                if (emt) void'(held.pop_front());
                if (acc) held.push_back(p);
            end
            if (held.size() > 0) last_main = held[0];
        end
        check_outputs();
    endtask

    initial begin
        payload_t a, b;
        rst = 1'b1; in_valid = 1'b0; ctrl_in = '0; rnum_in = '0; imm_in = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        held.delete();
        last_main = '0;
        exp_cnt = 0;

        // Reset then idle
        step(1'b0, mk(0, 0, 0), 1'b0, 1'b1, 1'b0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ctrl", 64'(ctrl_out), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        // Back-to-back stream
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, mk(22'(k * 3), 9'(k), 16'(k)), 1'b0, 1'b1, 1'b0);
            chk("stream_imm", 64'(imm_out), 64'(k));
            chk("stream_valid", 64'(out_valid), 64'd1);
        end
        step(1'b0, mk(0, 0, 0), 1'b0, 1'b1, 1'b0);

        // Stall, saturation and skid drain
        a = mk(22'h2AAAA, 9'h1A5, 16'h1111);
        b = mk(22'h15555, 9'h0C3, 16'h0055);
        step(1'b0, mk(0, 0, 0), 1'b0, 1'b0, 1'b1);
        step(1'b1, a, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, b, 1'b0, 1'b0, 1'b0);
        chk("stall_ctrl", 64'(ctrl_out), 64'h2AAAA);
        chk("stall_cnt5", 64'(stall_cnt), 64'd5);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("rnum_f1", 64'(rnum_field(64'(rnum_out), 1, 3)), 64'(rnum_field(64'(a.rnum), 1, 3)));
        for (int k = 0; k < 5; k++) step(1'b0, mk(0, 0, 0), 1'b0, 1'b0, 1'b0);
        chk("stall_sat", 64'(stall_cnt), 64'd7);
        step(1'b0, mk(0, 0, 0), 1'b0, 1'b1, 1'b0);
`ifdef PIPE_SKID_EN
        chk("drain_b_valid", 64'(out_valid), 64'd1);
        chk("drain_b_imm", 64'(imm_out), 64'h0055);
        chk("drain_ready_back", 64'(in_ready), 64'd1);
        step(1'b0, mk(0, 0, 0), 1'b0, 1'b1, 1'b0);
`endif
        chk("drained", 64'(out_valid), 64'd0);
        chk("sat_kept", 64'(stall_cnt), 64'd7);

        // Flush discards held payload and same-cycle accept
        step(1'b0, mk(0, 0, 0), 1'b0, 1'b0, 1'b1);
        step(1'b1, mk(22'h00123, 9'h011, 16'h1234), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(22'h3BEEF, 9'h1FF, 16'hBEEF), 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl", 64'(ctrl_out), 64'd0);
        step(1'b0, mk(0, 0, 0), 1'b0, 1'b1, 1'b0);
        chk("flush_no_beef", 64'(out_valid), 64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 7, mk(22'($urandom), 9'($urandom), 16'($urandom)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
